vga_timing_gen: RTL and testbench

VGA scan generator and output stage for the pacman display path. Runs 640x480@60 raster counters and publishes the current pixel coordinate as `xpos`/`ypos` to the graphics compositor. Registers the compositor's 8-bit `color` back, blanks it outside the active region, and expands it to the board's 4-bit-per-channel DAC. Emits aligned `hsync`/`vsync` and a one-cycle `frame_tick` for game/animation logic.

---
 rtl/vga_pkg.sv | 34 +++
 rtl/vga_axis_counter.sv | 47 ++++
 rtl/vga_timing_gen.sv | 132 +++++++++++++
 tb/tb_vga_timing_gen.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing defaults, RGB332 palette and colour expansion
// used by the scan generator and the pacman graphics compositor.
package vga_pkg;

  // 640x480@60 default timing, in pixels (horizontal) and lines (vertical)
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // RGB332 palette shared with the compositor: {R[2:0], G[2:0], B[1:0]}
  localparam logic [7:0] RED = 8'b111_000_00;
  localparam logic [7:0] PNK = 8'b111_101_11;
  localparam logic [7:0] CYN = 8'b000_111_11;
  localparam logic [7:0] ORG = 8'b111_100_00;
  localparam logic [7:0] YLW = 8'b111_111_00;
  localparam logic [7:0] WHT = 8'b111_111_11;
  localparam logic [7:0] CRM = 8'b111_111_10;
  localparam logic [7:0] BLU = 8'b000_000_11;
  localparam logic [7:0] BLK = 8'b000_000_00;

  // RGB332 -> 4:4:4 by replicating MSBs so full scale maps to 4'hF
  function automatic logic [11:0] expand_rgb332(input logic [7:0] c);
    return {c[7:5], c[7], c[4:2], c[4], c[1:0], c[1:0]};
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis (horizontal or vertical). Counts
// 0..TOTAL-1 on en, flags the active region, the negative sync window
// and the wrap cycle (wrap already includes en).
module vga_axis_counter #(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int W      = $clog2(ACTIVE + FP + SYNC + BP)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         in_active,
  output logic         sync_n,
  output logic         wrap
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT_END = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_LO = W'(ACTIVE + FP);
  localparam logic [W-1:0] SYNC_HI = W'(ACTIVE + FP + SYNC - 1);

  logic [W-1:0] count_q, count_d;

  // Next count: advance on en, wrap back to zero after the last position
  always_comb begin
    wrap    = en && (count_q == LAST);
    count_d = count_q;
    if (en) begin
      count_d = wrap ? '0 : count_q + W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign count     = count_q;
  assign in_active = (count_q < ACT_END);
  assign sync_n    = !((count_q >= SYNC_LO) && (count_q <= SYNC_HI));

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster generator and DAC output stage. Publishes the
// scan position, registers the compositor colour (blanked and expanded to
// 4 bits per channel) in the same stage as hsync/vsync, and pulses
// frame_tick once per frame. Define VGA_TEST_PATTERN_EN to replace the
// colour input with 64-pixel vertical bars derived from xpos.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] color,
  output logic [9:0] xpos,
  output logic [9:0] ypos,
  output logic       active,
  output logic       frame_tick,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       hsync,
  output logic       vsync
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             pix_en;
  logic [HW-1:0]    h_count;
  logic [VW-1:0]    v_count;
  logic             h_in_active, h_sync_n, h_wrap;
  logic             v_in_active, v_sync_n, v_wrap;
  logic [7:0]       pix_color;
  logic [11:0]      rgb_q, rgb_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             frame_tick_q, frame_tick_d;

  // Pixel-rate divider: pix_en on the last clk of each pixel period
  always_comb begin
    pix_en = (div_q == DIV_LAST);
    div_d  = pix_en ? '0 : div_q + DIV_W'(1);
  end

  // Divider register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) div_q <= '0;
    else      div_q <= div_d;
  end

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(HW)
  ) u_h_axis (
    .clk      (clk),
    .rst      (rst),
    .en       (pix_en),
    .count    (h_count),
    .in_active(h_in_active),
    .sync_n   (h_sync_n),
    .wrap     (h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(VW)
  ) u_v_axis (
    .clk      (clk),
    .rst      (rst),
    .en       (pix_en & h_wrap),
    .count    (v_count),
    .in_active(v_in_active),
    .sync_n   (v_sync_n),
    .wrap     (v_wrap)
  );

  assign xpos   = 10'(h_count);
  assign ypos   = 10'(v_count);
  assign active = h_in_active & v_in_active;

`ifdef VGA_TEST_PATTERN_EN
  assign pix_color = {{3{xpos[8]}}, {3{xpos[7]}}, {2{xpos[6]}}};
`else
  assign pix_color = color;
`endif

  // Output capture from the pre-increment position on each pix_en edge;
  // frame_tick marks the edge where the scan wraps back to (0,0)
  always_comb begin
    rgb_d        = rgb_q;
    hsync_d      = hsync_q;
    vsync_d      = vsync_q;
    frame_tick_d = pix_en & v_wrap;
    if (pix_en) begin
      rgb_d   = active ? expand_rgb332(pix_color) : 12'h000;
      hsync_d = h_sync_n;
      vsync_d = v_sync_n;
    end
  end

  // Output register stage: RGB, syncs and frame_tick stay aligned
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_q        <= 12'h000;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      rgb_q        <= rgb_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign {vga_r, vga_g, vga_b} = rgb_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of the VGA scan generator. u_dut runs
// the default 640x480 timing (reset, line timing, colour path, mid-frame
// reset); u_small runs a 16x10-pixel raster with CLK_DIV=1 so full frames
// fit in a short run (frame_tick spacing/width, vsync width).
module tb_vga_timing_gen;

  logic       clk;
  logic       rst;
  logic [7:0] color;
  logic [7:0] color_s;

  logic [9:0] xpos, ypos;
  logic       active, frame_tick, hsync, vsync;
  logic [3:0] vga_r, vga_g, vga_b;

  logic [9:0] xpos_s, ypos_s;
  logic       active_s, frame_tick_s, hsync_s, vsync_s;
  logic [3:0] vga_r_s, vga_g_s, vga_b_s;

  int n_cmp = 0;
  int n_err = 0;
  bit ft_seen = 1'b0;

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [11:0] EXP_X300 = 12'hF00;
`else
  localparam logic [11:0] EXP_X300 = 12'hFFF;
`endif

  vga_timing_gen u_dut (
    .clk       (clk),
    .rst       (rst),
    .color     (color),
    .xpos      (xpos),
    .ypos      (ypos),
    .active    (active),
    .frame_tick(frame_tick),
    .vga_r     (vga_r),
    .vga_g     (vga_g),
    .vga_b     (vga_b),
    .hsync     (hsync),
    .vsync     (vsync)
  );

  vga_timing_gen #(
    .CLK_DIV(1),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_small (
    .clk       (clk),
    .rst       (rst),
    .color     (color_s),
    .xpos      (xpos_s),
    .ypos      (ypos_s),
    .active    (active_s),
    .frame_tick(frame_tick_s),
    .vga_r     (vga_r_s),
    .vga_g     (vga_g_s),
    .vga_b     (vga_b_s),
    .hsync     (hsync_s),
    .vsync     (vsync_s)
  );

  // Clock: 10 ns period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The default-timing DUT never completes a frame in this run
  always @(negedge clk) if (frame_tick === 1'b1) ft_seen = 1'b1;

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Step until the default DUT shows (x,y); lands just after xpos advanced
  task automatic wait_xy(input int x, input int y);
    int n = 0;
    while (!(xpos == 10'(x) && ypos == 10'(y)) && n < 20000) begin
      step();
      n++;
    end
    chk("wait_xy_budget", 32'(n < 20000), 1);
  endtask

  initial begin
    int n;
    int ticks, vlow, hlow;
    logic [2:0]  kb;
    logic [11:0] exp_rgb;

    // ---- reset ----
    rst = 1'b0;
    color = 8'h00;
    color_s = 8'h00;
    step(5);
    chk("rst_xpos", xpos, 0);
    chk("rst_ypos", ypos, 0);
    chk("rst_rgb", {vga_r, vga_g, vga_b}, 0);
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_frame_tick", frame_tick, 0);
    chk("rst_active", active, 1);
    chk("rst_small_xpos", xpos_s, 0);
    chk("rst_small_sync", {hsync_s, vsync_s, frame_tick_s}, 3'b110);

    // ---- release: first pix_en two clks later ----
    rst = 1'b1;
    step();
    chk("rel_1clk_xpos", xpos, 0);
    step();
    chk("rel_2clk_xpos", xpos, 1);
    chk("rel_2clk_ypos", ypos, 0);

`ifdef VGA_TEST_PATTERN_EN
    // ---- test pattern bars on line 0 ----
    chk("pat_x0", {vga_r, vga_g, vga_b}, 12'h000);
    for (int k = 1; k < 8; k++) begin
      wait_xy(64 * k, 0);
      step(2);
      kb = 3'(k);
      exp_rgb = {{4{kb[2]}}, {4{kb[1]}}, {4{kb[0]}}};
      chk("pat_bar", {vga_r, vga_g, vga_b}, exp_rgb);
      if (k == 3) begin
        wait_xy(200, 0);
        step(2);
        chk("pat_x200", {vga_r, vga_g, vga_b}, 12'h0FF);
      end
    end
`endif

    // ---- line timing ----
    wait_xy(656, 0);
    step();
    chk("hsync_before_capture", hsync, 1);
    step();
    chk("hsync_fall", hsync, 0);
    chk("hsync_fall_xpos", xpos, 657);
    chk("vsync_line0", vsync, 1);
    n = 0;
    while (hsync == 1'b0 && n < 4000) begin
      step();
      n++;
    end
    chk("hsync_low_clks", n, 192);
    while (hsync == 1'b1 && n < 4000) begin
      step();
      n++;
    end
    chk("line_period_clks", n, 1600);

`ifndef VGA_TEST_PATTERN_EN
    // ---- colour path ----
    wait_xy(10, 10);
    color = 8'b11110100;
    step(2);
    chk("color_f4", {vga_r, vga_g, vga_b}, 12'hFB0);
    wait_xy(20, 10);
    color = 8'b00000011;
    step(2);
    chk("color_03", {vga_r, vga_g, vga_b}, 12'h00F);
    wait_xy(100, 10);
    color = 8'hFF;
    step(2);
    chk("color_ff_active", {vga_r, vga_g, vga_b}, 12'hFFF);
`endif
    wait_xy(700, 10);
    color = 8'hFF;
    chk("active_x700", active, 0);
    step(2);
    chk("blank_x700", {vga_r, vga_g, vga_b}, 12'h000);

    // ---- mid-frame reset ----
    wait_xy(300, 11);
    step(2);
    chk("pre_reset_rgb", {vga_r, vga_g, vga_b}, EXP_X300);
    rst = 1'b0;
    #1;
    chk("mid_rst_xpos", xpos, 0);
    chk("mid_rst_ypos", ypos, 0);
    chk("mid_rst_rgb", {vga_r, vga_g, vga_b}, 0);
    chk("mid_rst_sync", {hsync, vsync, frame_tick}, 3'b110);
    step(3);
    rst = 1'b1;
    step(2);
    chk("restart_xpos", xpos, 1);
    chk("restart_ypos", ypos, 0);

    // ---- frame timing on the small raster (16 x 10 px, 1 clk/px) ----
    n = 2;
    while (frame_tick_s !== 1'b1 && n < 1000) begin
      step();
      n++;
    end
    chk("first_tick_clks", n, 160);
    for (int f = 0; f < 2; f++) begin
      ticks = 0;
      vlow  = 0;
      hlow  = 0;
      for (int i = 0; i < 160; i++) begin
        step();
        if (frame_tick_s) ticks++;
        if (!vsync_s) vlow++;
        if (!hsync_s) hlow++;
      end
      chk("ticks_per_frame", ticks, 1);
      chk("tick_at_period", frame_tick_s, 1);
      chk("vsync_low_clks", vlow, 32);
      chk("hsync_low_per_frame", hlow, 30);
    end

    chk("no_default_tick", ft_seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
